fifo_thr: RTL and testbench

FIFO_THR -- requirements
Module: fifo_thr

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_thr.sv | 111 +++++++++++
 tb/tb_fifo_thr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and count-width helper.
package fifo_pkg;

   localparam int FWFT_REG  = 0;
   localparam int FWFT_FALL = 1;

   // Count must represent 0..DEPTH inclusive, hence one bit wider than the address.
   function automatic int cw_of(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];

endmodule

// File: rtl/fifo_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels and sticky
// overflow/underflow flags; FWFT selects fall-through or registered read data.
module fifo_thr
   import fifo_pkg::*;
#(
   parameter  int DEPTH  = 64,
   parameter  int DATA_W = 32,
   parameter  int FWFT   = 1,
   localparam int CW     = cw_of(DEPTH),
   localparam int AW     = CW - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              we,
   input  logic [DATA_W-1:0] wd,
   output logic              full,
   input  logic              re,
   output logic [DATA_W-1:0] rd,
   output logic              rd_vld,
   output logic              emp,
   output logic [CW-1:0]     cnt,
   input  logic [CW-1:0]     thr_full,
   input  logic [CW-1:0]     thr_emp,
   output logic              lvl_full,
   output logic              lvl_emp,
   output logic              ovf,
   output logic              udf,
   input  logic              err_clr
);

   logic [AW-1:0]     wr_addr;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] ram_rd;
   logic              wr_acc;
   logic              rd_acc;
   logic              ovf_evt;
   logic              udf_evt;

   assign full     = (cnt == CW'(DEPTH));
   assign emp      = (cnt == '0);
   assign lvl_full = (cnt >= thr_full);
   assign lvl_emp  = (cnt <= thr_emp);

   // Flush suppresses both acceptance and error reporting for that cycle.
   assign rd_acc  = re && !emp && !flush;
   assign wr_acc  = we && (!full || rd_acc) && !flush;
   assign ovf_evt = we && !wr_acc && !flush;
   assign udf_evt = re && emp && !flush;

   fifo_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk (clk),
      .we  (wr_acc),
      .wa  (wr_addr),
      .wd  (wd),
      .ra  (rd_addr),
      .rd  (ram_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         wr_addr <= '0;
         rd_addr <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else begin
         ovf <= ovf_evt || (ovf && !err_clr);
         udf <= udf_evt || (udf && !err_clr);
         if (flush) begin
            cnt     <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
         end else begin
            if (wr_acc) wr_addr <= wr_addr + 1'b1;
            if (rd_acc) rd_addr <= rd_addr + 1'b1;
            case ({wr_acc, rd_acc})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   if (FWFT != FWFT_REG) begin : g_fwft
      assign rd     = ram_rd;
      assign rd_vld = !emp;
   end else begin : g_reg
      logic [DATA_W-1:0] rd_q;
      logic              rd_vld_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
         end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc) rd_q <= ram_rd;
         end
      end

      assign rd     = rd_q;
      assign rd_vld = rd_vld_q;
   end

endmodule

// File: tb/tb_fifo_thr.sv
// Directed bench: a fall-through and a registered-read FIFO driven in lockstep.
module tb_fifo_thr;
   import fifo_pkg::*;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;
   localparam int CW     = cw_of(DEPTH);

   logic              clk = 1'b0;
   logic              rst, flush, we, re, err_clr;
   logic [DATA_W-1:0] wd;
   logic [CW-1:0]     thr_full, thr_emp;

   logic              full, rd_vld, emp, lvl_full, lvl_emp, ovf, udf;
   logic [DATA_W-1:0] rd;
   logic [CW-1:0]     cnt;

   logic              full_b, rd_vld_b, emp_b, lvl_full_b, lvl_emp_b, ovf_b, udf_b;
   logic [DATA_W-1:0] rd_b;
   logic [CW-1:0]     cnt_b;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   fifo_thr #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FWFT(FWFT_FALL)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .we(we), .wd(wd), .full(full),
      .re(re), .rd(rd), .rd_vld(rd_vld), .emp(emp), .cnt(cnt),
      .thr_full(thr_full), .thr_emp(thr_emp), .lvl_full(lvl_full),
      .lvl_emp(lvl_emp), .ovf(ovf), .udf(udf), .err_clr(err_clr)
   );

   fifo_thr #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FWFT(FWFT_REG)) u_dut_reg (
      .clk(clk), .rst(rst), .flush(flush), .we(we), .wd(wd), .full(full_b),
      .re(re), .rd(rd_b), .rd_vld(rd_vld_b), .emp(emp_b), .cnt(cnt_b),
      .thr_full(thr_full), .thr_emp(thr_emp), .lvl_full(lvl_full_b),
      .lvl_emp(lvl_emp_b), .ovf(ovf_b), .udf(udf_b), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      we = 1'b1; wd = d;
      tick();
      we = 1'b0;
   endtask

   task automatic pop();
      re = 1'b1;
      tick();
      re = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0; err_clr = 1'b0;
      wd = '0; thr_full = CW'(6); thr_emp = CW'(2);
      tick(); tick();
      rst = 1'b0;
      check("rst_cnt", 32'(cnt), 0);
      check("rst_emp", 32'(emp), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_udf", 32'(udf), 0);
      check("rst_rd_reg", 32'(rd_b), 0);
      check("rst_vld_reg", 32'(rd_vld_b), 0);

      // Fill 0x10..0x17, then one dropped write.
      for (int i = 0; i < 8; i++) begin
         push(8'(8'h10 + i));
         check("fill_cnt", 32'(cnt), 32'(i + 1));
         check("fill_lvl_full", 32'(lvl_full), 32'((i + 1) >= 6));
         check("fill_full", 32'(full), 32'((i + 1) == 8));
         if (i == 0) check("fwft_first", 32'(rd), 32'h10);
      end
      push(8'hEE);
      check("ovf_set", 32'(ovf), 1);
      check("ovf_cnt", 32'(cnt), 8);

      // Drain with fall-through data.
      for (int i = 0; i < 8; i++) begin
         check("drain_rd", 32'(rd), 32'(8'h10 + i));
         check("drain_vld", 32'(rd_vld), 1);
         pop();
         check("drain_cnt", 32'(cnt), 32'(7 - i));
         check("drain_lvl_emp", 32'(lvl_emp), 32'((7 - i) <= 2));
      end
      check("drain_emp", 32'(emp), 1);
      check("drain_vld_emp", 32'(rd_vld), 0);
      pop();
      check("udf_set", 32'(udf), 1);
      check("udf_cnt", 32'(cnt), 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("udf_clr", 32'(udf), 0);
      check("ovf_clr", 32'(ovf), 0);

      // Registered read: rd_vld pulses exactly once, the cycle after re.
      push(8'hA5);
      tick();
      check("reg_vld_idle", 32'(rd_vld_b), 0);
      pop();
      check("reg_rd", 32'(rd_b), 32'hA5);
      check("reg_vld", 32'(rd_vld_b), 1);
      tick();
      check("reg_vld_pulse", 32'(rd_vld_b), 0);
      check("reg_rd_hold", 32'(rd_b), 32'hA5);

      // Simultaneous write and read while full.
      for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
      check("sim_full", 32'(full), 1);
      we = 1'b1; re = 1'b1; wd = 8'h55;
      tick();
      we = 1'b0; re = 1'b0;
      check("sim_full_cnt", 32'(cnt), 8);
      check("sim_full_ovf", 32'(ovf), 0);
      for (int i = 0; i < 8; i++) begin
         check("sim_rd", 32'(rd), (i < 7) ? 32'(8'h21 + i) : 32'h55);
         pop();
      end
      check("sim_drained", 32'(cnt), 0);

      // Simultaneous write and read while empty: read ignored.
      we = 1'b1; re = 1'b1; wd = 8'h66;
      tick();
      we = 1'b0; re = 1'b0;
      check("sim_emp_cnt", 32'(cnt), 1);
      check("sim_emp_udf", 32'(udf), 1);
      check("sim_emp_rd", 32'(rd), 32'h66);
      pop();
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // Interleaved traffic across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         push(8'(i));
         check("wrap_rd", 32'(rd), 32'(i));
         check("wrap_cnt1", 32'(cnt), 1);
         pop();
         check("wrap_cnt0", 32'(cnt), 0);
      end

      // Flush keeps sticky flags and ignores concurrent we/re.
      pop();
      check("pre_flush_udf", 32'(udf), 1);
      for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
      check("pre_flush_cnt", 32'(cnt), 5);
      flush = 1'b1; we = 1'b1; re = 1'b1; wd = 8'h77;
      tick();
      flush = 1'b0; we = 1'b0; re = 1'b0;
      check("flush_cnt", 32'(cnt), 0);
      check("flush_emp", 32'(emp), 1);
      check("flush_udf", 32'(udf), 1);
      check("flush_ovf", 32'(ovf), 0);
      check("flush_vld_reg", 32'(rd_vld_b), 0);

      // Reset mid-operation with cnt=5 and ovf set.
      for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
      push(8'hEE);
      for (int i = 0; i < 3; i++) pop();
      check("pre_rst_cnt", 32'(cnt), 5);
      check("pre_rst_ovf", 32'(ovf), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst2_cnt", 32'(cnt), 0);
      check("rst2_emp", 32'(emp), 1);
      check("rst2_full", 32'(full), 0);
      check("rst2_ovf", 32'(ovf), 0);
      check("rst2_udf", 32'(udf), 0);
      check("rst2_lvl_full", 32'(lvl_full), 0);
      check("rst2_lvl_emp", 32'(lvl_emp), 1);
      check("rst2_vld", 32'(rd_vld), 0);
      check("rst2_rd_reg", 32'(rd_b), 0);
      check("rst2_vld_reg", 32'(rd_vld_b), 0);

      // Threshold extremes.
      thr_full = '0; thr_emp = CW'(DEPTH);
      #1;
      check("thr_full_zero", 32'(lvl_full), 1);
      check("thr_emp_depth", 32'(lvl_emp), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
